// File: rtl/mux_demux_pkg.sv
// Shared types and constants for the logic-equation self-check harness.
package mux_demux_pkg;

  localparam int SETTLE_W = 4;
  localparam logic [7:0] DEFAULT_MINTERMS = 8'h5B;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks all 8 {A,B,C} combinations into a logic-equation block, captures Y for
// each and compares the resulting truth table against an expected minterm mask.
module truth_table_sweeper
  import mux_demux_pkg::*;
#(
  parameter logic [7:0] EXP_MINTERMS = DEFAULT_MINTERMS,
  parameter int         SETTLE       = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       y_i,
  output logic [2:0] abc_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] table_o,
  output logic [7:0] mismatch_o,
  output logic       pass_o
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [2:0]          abc_d;
  logic [7:0]          table_d, mismatch_d;
  logic                pass_d, done_d, busy_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      abc_o      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      table_o    <= '0;
      mismatch_o <= '0;
      pass_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      abc_o      <= abc_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      table_o    <= table_d;
      mismatch_o <= mismatch_d;
      pass_o     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    abc_d      = abc_o;
    table_d    = table_o;
    mismatch_d = mismatch_o;
    pass_d     = pass_o;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = DRIVE;
          table_d    = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          abc_d      = '0;
          cnt_d      = RELOAD;
        end
      end
      DRIVE: begin
        abc_d = idx_q;
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        table_d[idx_q] = y_i;
        // Verdict is formed from the table including this final sample.
        if (idx_q == 3'd7) begin
          state_d    = DONE;
          mismatch_d = table_d ^ EXP_MINTERMS;
          pass_d     = (table_d == EXP_MINTERMS);
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          cnt_d   = RELOAD;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
  end

endmodule
